pipe_ex_unit: RTL and testbench



---
 rtl/pipe_ex_unit.sv | 54 +++++
 tb/tb_pipe_ex_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ex_unit.sv
// Three-stage pipelined datapath: f = ((a + b) + (c - d)) * d, unsigned modulo 2^N.
// Define PIPE_EX_SAT_EN to clamp the final product to 2^N-1 instead of truncating.
module pipe_ex_unit #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic         in_valid,
    output logic [N-1:0] f,
    output logic         out_valid
);
    localparam int STAGES = 3;

    // vld_pipe[1] is the stage-1 valid, vld_pipe[2] the stage-2 valid, vld_pipe[3] drives out_valid
    logic [STAGES:1] vld_pipe;
    logic [N-1:0]    s1_x1, s1_x2, s1_d;
    logic [N-1:0]    s2_x3, s2_d;
    logic [N-1:0]    f_next;

`ifdef PIPE_EX_SAT_EN
    logic [2*N-1:0] prod;
    assign prod   = {{N{1'b0}}, s2_x3} * {{N{1'b0}}, s2_d};
    assign f_next = (|prod[2*N-1:N]) ? {N{1'b1}} : prod[N-1:0];
`else
    assign f_next = s2_x3 * s2_d;
`endif

    // Data advances every cycle; in_valid only qualifies it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_d     <= '0;
            s2_x3    <= '0;
            s2_d     <= '0;
            f        <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_x1    <= a + b;
            s1_x2    <= c - d;
            s1_d     <= d;
            s2_x3    <= s1_x1 + s1_x2;
            s2_d     <= s1_d;
            f        <= f_next;
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_pipe_ex_unit.sv
// Scoreboard bench for pipe_ex_unit: driver pushes expected results with their due edge,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_pipe_ex_unit;
    localparam int N = 10;
    localparam longint M = longint'(1) << N;

    logic         clk;
    logic         rst;
    logic [N-1:0] a, b, c, d;
    logic         in_valid;
    logic [N-1:0] f;
    logic         out_valid;

    typedef struct {
        int           due;
        logic [N-1:0] f;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    logic rst_q    = 1'b0;
    logic idle_chk = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    pipe_ex_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .f(f), .out_valid(out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_q    <= rst;
    end

    // Reference: plain integer arithmetic straight from the defining formula.
    function automatic logic [N-1:0] model(input int ta, tb, tc, td);
        longint x1, x2, x3, p;
        x1 = (longint'(ta) + tb) % M;
        x2 = (longint'(tc) - td + M) % M;
        x3 = (x1 + x2) % M;
        p  = x3 * td;
`ifdef PIPE_EX_SAT_EN
        if (p > M - 1) p = M - 1;
        return N'(p);
`else
        return N'(p % M);
`endif
    endfunction

    // ef < 0 means take the expected value from the model.
    task automatic drive(input int ta, tb, tc, td, input logic v, input logic r, input int ef);
        exp_t e;
        @(negedge clk);
        #1;
        a = N'(ta); b = N'(tb); c = N'(tc); d = N'(td);
        in_valid = v;
        rst = r;
        if (r) q.delete();
        else if (v) begin
            e.due = edge_cnt + 3;
            e.f   = (ef < 0) ? model(ta, tb, tc, td) : N'(ef);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            checks++;
            if (f !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_clear edge=%0d f=%0d out_valid=%b want f=0 out_valid=0", edge_cnt, f, out_valid);
            end
        end else if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0 || q[0].due != edge_cnt) begin
                errors++;
                $display("FAIL unexpected_valid edge=%0d f=%0d due=%0d", edge_cnt, f,
                         (q.size() == 0) ? -1 : q[0].due);
            end else begin
                if (f !== q[0].f) begin
                    errors++;
                    $display("FAIL result edge=%0d f=%0d want %0d", edge_cnt, f, q[0].f);
                end
                void'(q.pop_front());
            end
        end else if (q.size() > 0 && q[0].due == edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL missing_valid edge=%0d out_valid=%b want 1 (f want %0d)", edge_cnt, out_valid, q[0].f);
            void'(q.pop_front());
        end
        if (idle_chk) begin
            checks++;
            if (f !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle edge=%0d f=%0d out_valid=%b want 0 0", edge_cnt, f, out_valid);
            end
        end
    end

    int st[8][5] = '{
        '{10, 12, 6, 3, 75},  '{10, 10, 5, 3, 66},  '{11, 11, 1, 4, 76},  '{15, 22, 1, 5, 165},
        '{9, 11, 9, 5, 120},  '{19, 19, 5, 7, 252}, '{10, 10, 5, 3, 66},  '{17, 12, 5, 9, 225}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        a = '0; b = '0; c = '0; d = '0;

        // Reset held for 5 cycles, then idle with zero operands.
        repeat (5) drive(0, 0, 0, 0, 1'b0, 1'b1, -1);
        idle_chk = 1'b1;
        repeat (6) drive(0, 0, 0, 0, 1'b0, 1'b0, -1);
        idle_chk = 1'b0;

        // Directed stream with fixed expected results.
        for (int i = 0; i < 8; i++) drive(st[i][0], st[i][1], st[i][2], st[i][3], 1'b1, 1'b0, st[i][4]);

`ifdef PIPE_EX_SAT_EN
        drive(300, 0, 10, 5, 1'b1, 1'b0, 1023);
`else
        drive(300, 0, 10, 5, 1'b1, 1'b0, 501);
`endif
        drive(1023, 1023, 1023, 0, 1'b1, 1'b0, 0);

        // Valid gaps 1,0,1.
        drive($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, 1'b0, -1);
        drive($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b0, -1);
        drive($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, 1'b0, -1);

        // Reset with three sets in flight, then a fresh valid set.
        drive(0, 0, 0, 0, 1'b0, 1'b0, -1);
        drive(0, 0, 0, 0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) drive(100 + i, 7, 50, 3 + i, 1'b1, 1'b0, -1);
        drive(5, 5, 5, 5, 1'b1, 1'b1, -1);
        drive(10, 12, 6, 3, 1'b1, 1'b0, 75);
        repeat (4) drive(0, 0, 0, 0, 1'b0, 1'b0, -1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic rv, rr;
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                  (i % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1023), rv, rr, -1);
        end

        repeat (5) drive(0, 0, 0, 0, 1'b0, 1'b0, -1);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
